// File: rtl/touch_panel_scanner_if.sv
// Register-port bus between the touch-panel scanner and the SPI master core.
// The scanner is the bus master; the SPI core is the slave.
interface touch_panel_scanner_if;
    logic        spi_select;
    logic [2:0]  spi_mem_addr;
    logic        spi_write_n;
    logic        spi_read_n;
    logic [15:0] spi_data_from_cpu;
    logic [15:0] spi_data_to_cpu;
    logic        spi_readyfordata;
    logic        spi_dataavailable;

    modport master (
        output spi_select, spi_mem_addr, spi_write_n, spi_read_n, spi_data_from_cpu,
        input  spi_data_to_cpu, spi_readyfordata, spi_dataavailable
    );

    modport slave (
        input  spi_select, spi_mem_addr, spi_write_n, spi_read_n, spi_data_from_cpu,
        output spi_data_to_cpu, spi_readyfordata, spi_dataavailable
    );
endinterface

// File: rtl/touch_panel_scanner.sv
// Periodic X/Y reader for an ADS7843-style touch controller, driving the SPI
// core register port so software no longer has to poll the touch path.
module touch_panel_scanner #(
    parameter int unsigned SAMPLE_PERIOD = 600000,
    parameter int unsigned TIMEOUT       = 65535,
    parameter logic [7:0]  CMD_X         = 8'hD0,
    parameter logic [7:0]  CMD_Y         = 8'h90
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable_i,
    input  logic                  pen_irq_n_i,
    touch_panel_scanner_if.master spi,
    output logic [11:0]           x_pos_o,
    output logic [11:0]           y_pos_o,
    output logic                  sample_valid_o,
    output logic                  pen_down_o,
    output logic                  busy_o,
    output logic                  timeout_err_o
);
    localparam int PW = $clog2(SAMPLE_PERIOD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [TW-1:0] WAIT_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR_ST, S_SS_ON, S_TX_WAIT, S_TX_WR,
        S_RX_WAIT, S_RX_RD, S_NEXT, S_SS_OFF, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [1:0]    byte_q, byte_d;
    logic          chan_q, chan_d;
    logic [PW-1:0] period_q, period_d;
    logic          timeout_err_q, timeout_err_d;
    logic [1:0]    pen_sync_q;
    logic          pen_down_q;
    logic [6:0]    hi_q;
    logic [11:0]   x_tmp_q, y_tmp_q, x_pos_q, y_pos_q;

    logic          bus_sel, bus_wr_n, bus_rd_n;
    logic [2:0]    bus_addr;
    logic [15:0]   bus_wdata;
    logic          sample_valid, load_pos, capture_hi, capture_lo;
    logic          acc_last;
    logic [7:0]    tx_byte;

    // An access is phases 0 and 1 with the strobe held, phase 2 fully idle.
    assign acc_last = (phase_q == 2'd2);
    assign tx_byte  = (byte_q == 2'd0) ? (chan_q ? CMD_Y : CMD_X) : 8'h00;

    always_comb begin
        state_d       = state_q;
        phase_d       = 2'd0;
        wait_d        = '0;
        byte_d        = byte_q;
        chan_d        = chan_q;
        period_d      = '0;
        timeout_err_d = timeout_err_q;
        bus_sel       = 1'b0;
        bus_addr      = 3'd0;
        bus_wr_n      = 1'b1;
        bus_rd_n      = 1'b1;
        bus_wdata     = 16'h0000;
        sample_valid  = 1'b0;
        load_pos      = 1'b0;
        capture_hi    = 1'b0;
        capture_lo    = 1'b0;

        unique case (state_q)
            S_CLR_ST, S_SS_ON, S_TX_WR, S_RX_RD, S_SS_OFF: begin
                phase_d = acc_last ? 2'd0 : phase_q + 2'd1;
                bus_sel = !acc_last;
            end
            default: ;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    if (period_q == PERIOD_LAST) begin
                        if (pen_down_q) begin
                            state_d       = S_CLR_ST;
                            timeout_err_d = 1'b0;
                            byte_d        = 2'd0;
                            chan_d        = 1'b0;
                        end
                    end else begin
                        period_d = period_q + 1'b1;
                    end
                end
            end
            S_CLR_ST: begin
                bus_addr = 3'd2;
                bus_wr_n = acc_last;
                if (acc_last) state_d = S_SS_ON;
            end
            S_SS_ON: begin
                bus_addr  = 3'd3;
                bus_wr_n  = acc_last;
                bus_wdata = acc_last ? 16'h0000 : 16'h0400;
                if (acc_last) state_d = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (spi.spi_readyfordata) begin
                    state_d = S_TX_WR;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_SS_OFF;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_TX_WR: begin
                bus_addr  = 3'd1;
                bus_wr_n  = acc_last;
                bus_wdata = acc_last ? 16'h0000 : {8'h00, tx_byte};
                if (acc_last) state_d = S_RX_WAIT;
            end
            S_RX_WAIT: begin
                if (spi.spi_dataavailable) begin
                    state_d = S_RX_RD;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_SS_OFF;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_RX_RD: begin
                bus_addr   = 3'd0;
                bus_rd_n   = acc_last;
                capture_hi = (phase_q == 2'd1) && (byte_q == 2'd1);
                capture_lo = (phase_q == 2'd1) && (byte_q == 2'd2);
                if (acc_last) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (byte_q == 2'd2) begin
                    byte_d  = 2'd0;
                    chan_d  = 1'b1;
                    state_d = chan_q ? S_SS_OFF : S_TX_WAIT;
                end else begin
                    byte_d  = byte_q + 2'd1;
                    state_d = S_TX_WAIT;
                end
            end
            S_SS_OFF: begin
                bus_addr = 3'd3;
                bus_wr_n = acc_last;
                if (acc_last) begin
                    state_d  = S_DONE;
                    load_pos = !timeout_err_q;
                end
            end
            S_DONE: begin
                sample_valid = !timeout_err_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            phase_q       <= 2'd0;
            wait_q        <= '0;
            byte_q        <= 2'd0;
            chan_q        <= 1'b0;
            period_q      <= '0;
            timeout_err_q <= 1'b0;
            pen_sync_q    <= 2'b11;
            pen_down_q    <= 1'b0;
            hi_q          <= 7'd0;
            x_tmp_q       <= 12'd0;
            y_tmp_q       <= 12'd0;
            x_pos_q       <= 12'd0;
            y_pos_q       <= 12'd0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            wait_q        <= wait_d;
            byte_q        <= byte_d;
            chan_q        <= chan_d;
            period_q      <= period_d;
            timeout_err_q <= timeout_err_d;
            pen_sync_q    <= {pen_sync_q[0], pen_irq_n_i};
            // PENIRQ is meaningless while the controller converts
            if (state_q == S_IDLE) pen_down_q <= ~pen_sync_q[1];
            if (capture_hi) hi_q <= spi.spi_data_to_cpu[6:0];
            if (capture_lo) begin
                if (chan_q) y_tmp_q <= {hi_q, spi.spi_data_to_cpu[7:3]};
                else        x_tmp_q <= {hi_q, spi.spi_data_to_cpu[7:3]};
            end
            if (load_pos) begin
                x_pos_q <= x_tmp_q;
                y_pos_q <= y_tmp_q;
            end
        end
    end

    assign spi.spi_select        = bus_sel;
    assign spi.spi_mem_addr      = bus_addr;
    assign spi.spi_write_n       = bus_wr_n;
    assign spi.spi_read_n        = bus_rd_n;
    assign spi.spi_data_from_cpu = bus_wdata;

    assign x_pos_o        = x_pos_q;
    assign y_pos_o        = y_pos_q;
    assign sample_valid_o = sample_valid;
    assign pen_down_o     = pen_down_q;
    assign busy_o         = (state_q != S_IDLE);
    assign timeout_err_o  = timeout_err_q;
endmodule

// File: tb/tb_touch_panel_scanner.sv
// Scoreboard bench: behavioural SPI core + MISO queue, bus-protocol checker,
// and a sample monitor that pops expected X/Y pairs on every sample_valid.
module tb_touch_panel_scanner;
    localparam int SP    = 100;
    localparam int TO    = 50;
    localparam int SHIFT = 20;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic pen_irq_n = 1'b1;
    always #5 clk = ~clk;

    touch_panel_scanner_if bus();
    logic [11:0] x_pos, y_pos;
    logic sample_valid, pen_down, busy, timeout_err;

    touch_panel_scanner #(.SAMPLE_PERIOD(SP), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .enable_i(enable), .pen_irq_n_i(pen_irq_n),
        .spi(bus), .x_pos_o(x_pos), .y_pos_o(y_pos), .sample_valid_o(sample_valid),
        .pen_down_o(pen_down), .busy_o(busy), .timeout_err_o(timeout_err)
    );

    int asserts = 0;
    int fails = 0;
    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // ---------------- SPI core model ----------------
    logic [7:0]  miso_q[$];
    logic        prev_sel, sso, shifting, rrdy, force_no_rrdy = 1'b0;
    int          shcnt;
    logic [7:0]  rx_byte;
    logic [15:0] rdata;

    assign bus.spi_readyfordata  = !shifting;
    assign bus.spi_dataavailable = rrdy;
    assign bus.spi_data_to_cpu   = rdata;

    always @(posedge clk) begin
        if (!reset_n) begin
            prev_sel <= 1'b0; sso <= 1'b0; shifting <= 1'b0; rrdy <= 1'b0;
            shcnt <= 0; rdata <= 16'h0; rx_byte <= 8'h0;
        end else begin
            prev_sel <= bus.spi_select;
            if (bus.spi_select && !prev_sel) begin
                if (!bus.spi_write_n) begin
                    case (bus.spi_mem_addr)
                        3'd1: begin
                            shifting <= 1'b1;
                            shcnt    <= SHIFT;
                            rx_byte  <= (miso_q.size() > 0) ? miso_q.pop_front() : 8'h00;
                        end
                        3'd2: rrdy <= 1'b0;
                        3'd3: sso  <= bus.spi_data_from_cpu[10];
                        default: ;
                    endcase
                end
                if (!bus.spi_read_n && bus.spi_mem_addr == 3'd0) rrdy <= 1'b0;
            end
            if (shifting) begin
                if (shcnt <= 1) begin
                    shifting <= 1'b0;
                    if (!force_no_rrdy) rrdy <= 1'b1;
                    rdata <= {8'h00, rx_byte};
                end else begin
                    shcnt <= shcnt - 1;
                end
            end
        end
    end

    // ---------------- bus protocol checker ----------------
    logic [2:0]  exp_addr_q[$];
    logic        addr_chk_en = 1'b1;
    int          acc_count = 0;
    int          bytes_in_scan = 0;
    int          acc_start_log[$];
    int          run_len = 0;
    logic [20:0] rec;

    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            run_len = 0;
        end else if (bus.spi_select) begin
            if (run_len == 0) begin
                rec = {bus.spi_mem_addr, bus.spi_write_n, bus.spi_read_n, bus.spi_data_from_cpu};
                acc_count++;
                acc_start_log.push_back(cycle);
                chk("one_strobe", bus.spi_write_n ^ bus.spi_read_n, 1);
                if (addr_chk_en) begin
                    if (exp_addr_q.size() == 0) begin
                        asserts++; fails++;
                        $display("FAIL addr_unexpected: got %0d expected no access", bus.spi_mem_addr);
                    end else begin
                        chk("addr_seq", bus.spi_mem_addr, exp_addr_q.pop_front());
                    end
                end
                if (bus.spi_mem_addr == 3'd1 && !bus.spi_write_n) begin
                    chk("ss_n_low", sso, 1);
                    bytes_in_scan++;
                end
            end else begin
                chk("access_hold",
                    {bus.spi_mem_addr, bus.spi_write_n, bus.spi_read_n, bus.spi_data_from_cpu}, rec);
            end
            run_len++;
        end else begin
            if (run_len > 0) chk("access_len", run_len, 2);
            if (!bus.spi_write_n || !bus.spi_read_n) begin
                asserts++; fails++;
                $display("FAIL strobe_idle: wr_n=%0b rd_n=%0b expected 1/1 with select low",
                         bus.spi_write_n, bus.spi_read_n);
            end
            run_len = 0;
        end
    end

    // ---------------- sample scoreboard ----------------
    logic [23:0] exp_q[$];
    logic [23:0] e;
    int          pulses = 0;

    initial forever begin
        @(negedge clk);
        if (reset_n && sample_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                asserts++; fails++;
                $display("FAIL sample_unexpected: x=%0h y=%0h expected no pulse", x_pos, y_pos);
            end else begin
                e = exp_q.pop_front();
                chk("x_pos", x_pos, e[23:12]);
                chk("y_pos", y_pos, e[11:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int n = 0;
        while (busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, lvl);
    endtask

    task automatic push_good_addrs();
        exp_addr_q.push_back(3'd2);
        exp_addr_q.push_back(3'd3);
        for (int i = 0; i < 6; i++) begin
            exp_addr_q.push_back(3'd1);
            exp_addr_q.push_back(3'd0);
        end
        exp_addr_q.push_back(3'd3);
    endtask

    task automatic issue_scan(input logic [47:0] bytes, input logic [23:0] exp, input bit good);
        for (int i = 0; i < 6; i++) miso_q.push_back(bytes[47-8*i -: 8]);
        if (good) exp_q.push_back(exp);
        acc_start_log.delete();
        bytes_in_scan = 0;
        pen_irq_n = 1'b0;
        wait_busy(1'b1, 3*SP, "scan_start");
        chk("pen_down_in_scan", pen_down, 1);
        pen_irq_n = 1'b1;
    endtask

    task automatic finish_good_scan(input int p0, input string tag);
        wait_busy(1'b0, 3000, "scan_end");
        @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        chk("one_pulse", pulses - p0, 1);
        chk("addr_all_seen", exp_addr_q.size(), 0);
        chk("ss_released", sso, 0);
        $display("scan %s done: x=%0h y=%0h pulses=%0d", tag, x_pos, y_pos, pulses - p0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_select", bus.spi_select, 0);
        chk("rst_write_n", bus.spi_write_n, 1);
        chk("rst_read_n", bus.spi_read_n, 1);
        chk("rst_addr", bus.spi_mem_addr, 0);
        chk("rst_wdata", bus.spi_data_from_cpu, 0);
        chk("rst_x", x_pos, 0);
        chk("rst_y", y_pos, 0);
        chk("rst_sv", sample_valid, 0);
        chk("rst_pen_down", pen_down, 0);
        chk("rst_busy", busy, 0);
        chk("rst_terr", timeout_err, 0);
    endtask

    initial begin
        int a0, p0, n, t0;
        bit seen;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        $display("reset check done");

        // pen up: five periods without any access
        enable = 1'b1;
        a0 = acc_count;
        seen = 0;
        repeat (5*SP + 10) begin
            @(negedge clk);
            if (busy !== 1'b0) seen = 1;
        end
        chk("penup_busy", seen, 0);
        chk("penup_no_access", acc_count, a0);
        chk("penup_pen_down", pen_down, 0);
        $display("pen-up window done: accesses=%0d", acc_count - a0);

        // nominal scan
        p0 = pulses;
        push_good_addrs();
        issue_scan(48'h00_5A_C8_00_12_34, {12'hB59, 12'h246}, 1'b1);
        finish_good_scan(p0, "nominal");

        // all-ones / ignored-bit boundary
        p0 = pulses;
        push_good_addrs();
        issue_scan(48'hFF_FF_FF_00_80_07, {12'hFFF, 12'h000}, 1'b1);
        finish_good_scan(p0, "boundary");

        // dataavailable never rises
        force_no_rrdy = 1'b1;
        p0 = pulses;
        exp_addr_q.push_back(3'd2);
        exp_addr_q.push_back(3'd3);
        exp_addr_q.push_back(3'd1);
        exp_addr_q.push_back(3'd3);
        issue_scan(48'h00_11_22_00_33_44, 24'h0, 1'b0);
        wait_busy(1'b0, 3000, "timeout_scan_end");
        @(negedge clk);
        chk("timeout_err_set", timeout_err, 1);
        chk("timeout_x_kept", x_pos, 12'hFFF);
        chk("timeout_y_kept", y_pos, 12'h000);
        chk("timeout_no_pulse", pulses - p0, 0);
        chk("timeout_addr_seen", exp_addr_q.size(), 0);
        if (acc_start_log.size() >= 4)
            chk("timeout_wait_cycles", acc_start_log[3] - acc_start_log[2], 53);
        else
            chk("timeout_access_count", acc_start_log.size(), 4);
        $display("timeout scan done: timeout_err=%0b x=%0h", timeout_err, x_pos);
        force_no_rrdy = 1'b0;
        miso_q.delete();

        // next good scan clears the sticky error
        p0 = pulses;
        push_good_addrs();
        issue_scan(48'h00_01_02_00_7F_F8, {12'h020, 12'hFFF}, 1'b1);
        chk("timeout_err_cleared", timeout_err, 0);
        finish_good_scan(p0, "recovery");

        // reset while waiting for RX data
        addr_chk_en = 1'b0;
        issue_scan(48'h00_11_22_00_33_44, 24'h0, 1'b0);
        n = 0;
        while (bytes_in_scan < 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_rx_wait", bytes_in_scan >= 2, 1);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        reset_n = 1'b1;
        t0 = cycle;
        miso_q.delete();
        exp_addr_q.delete();
        addr_chk_en = 1'b1;
        $display("mid-scan reset applied");

        p0 = pulses;
        push_good_addrs();
        issue_scan(48'h00_5A_C8_00_12_34, {12'hB59, 12'h246}, 1'b1);
        chk("restart_after_period", (cycle - t0) >= SP, 1);
        finish_good_scan(p0, "post-reset");

        // enable dropped during channel Y
        p0 = pulses;
        push_good_addrs();
        issue_scan(48'h00_AB_CD_00_3C_5F, {12'h579, 12'h78B}, 1'b1);
        n = 0;
        while (bytes_in_scan < 4 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_channel_y", bytes_in_scan >= 4, 1);
        enable = 1'b0;
        finish_good_scan(p0, "enable-drop");
        a0 = acc_count;
        pen_irq_n = 1'b0;
        seen = 0;
        repeat (3*SP) begin
            @(negedge clk);
            if (busy !== 1'b0) seen = 1;
        end
        chk("disabled_busy", seen, 0);
        chk("disabled_no_access", acc_count, a0);
        $display("disabled window done: accesses=%0d", acc_count - a0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/touch_panel_scanner.md
# touch_panel_scanner

Autonomous sequencer for the touch-panel SPI master (8-bit, CPOL=0/CPHA=0, one slave, 32 kHz SCLK). It drives the SPI core's register port to periodically read the ADS7843-style touch controller while the pen is down. It assembles 12-bit X/Y results and presents them to the video/overlay logic, so the Nios II no longer polls the touch path.

## Interface
Parameters:
- SAMPLE_PERIOD, 600000: clk cycles between scan attempts (10 ms at 60 MHz).
- TIMEOUT, 65535: max clk cycles to wait for any single SPI handshake.
- CMD_X, 8'hD0: command byte for the X channel (12-bit, differential, PD=00).
- CMD_Y, 8'h90: command byte for the Y channel.

Ports:
- clk  in  1  system clock (60 MHz, same as the SPI core)
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  allows scans to start
- pen_irq_n  in  1  asynchronous PENIRQ from the touch controller, low = touched
- spi_select  out  1  SPI core chip select
- spi_mem_addr  out  3  SPI core register address
- spi_write_n  out  1  SPI core write strobe, active low
- spi_read_n  out  1  SPI core read strobe, active low
- spi_data_from_cpu  out  16  write data to the SPI core
- spi_data_to_cpu  in  16  registered read data from the SPI core
- spi_readyfordata  in  1  SPI core TRDY
- spi_dataavailable  in  1  SPI core RRDY
- x_pos  out  12  last valid X result
- y_pos  out  12  last valid Y result
- sample_valid  out  1  1-cycle pulse when x_pos/y_pos update
- pen_down  out  1  synchronized pen state, sampled in IDLE only
- busy  out  1  scan in progress
- timeout_err  out  1  sticky; set on a handshake timeout, cleared at the next scan start

## Operation
- pen_irq_n passes through a 2-FF synchronizer. pen_down updates only in IDLE, because PENIRQ is invalid during conversions.
- Period counter: 0..SAMPLE_PERIOD-1, runs while enable=1, cleared while enable=0.
- A scan starts at wrap when pen_down=1; if the pen is up, the counter just wraps.
- Bus access primitive: select, addr, data and strobe are held for exactly 2 cycles, then 1 idle cycle with everything deasserted (select=0, read_n=write_n=1). Read data is captured on the edge ending the second active cycle. A held 3rd cycle is forbidden, since the core would see a second access.
- FSM states:
  - IDLE
  - CLR_ST: write addr 2, data 0; clears stale status.
  - SS_ON: write addr 3, data 16'h0400; sets SSO so SS_n stays low across all 6 bytes.
  - TX_WAIT: wait spi_readyfordata=1.
  - TX_WR: write addr 1, data {8'h00, byte}.
  - RX_WAIT: wait spi_dataavailable=1.
  - RX_RD: read addr 0.
  - NEXT
  - SS_OFF: write addr 3, data 0.
  - DONE
- Byte order per channel (X then Y):
  - byte0 = CMD, readback discarded.
  - byte1 = 8'h00, readback = hi.
  - byte2 = 8'h00, readback = lo.
- NEXT advances the byte index 0..2 and then the channel 0..1. After channel 1 byte 2 it goes to SS_OFF.
- Result = {hi[6:0], lo[7:3]}. hi[7] and lo[2:0] are ignored.
- DONE: x_pos/y_pos load together and sample_valid pulses for 1 cycle, then the FSM returns to IDLE and the period counter restarts from 0.
- Timeout: a per-wait counter in TX_WAIT/RX_WAIT. Reaching TIMEOUT sets timeout_err and jumps to SS_OFF. x_pos/y_pos keep their old values and sample_valid is not pulsed.
- enable dropping mid-scan: the scan completes normally, then the FSM stays IDLE.
- busy=1 in every state except IDLE.

## Timing
- Reset values:
  - spi_select=0, spi_write_n=1, spi_read_n=1, spi_mem_addr=0, spi_data_from_cpu=0
  - x_pos=0, y_pos=0, sample_valid=0, pen_down=0, busy=0, timeout_err=0
  - FSM=IDLE, counters=0
- Reset mid-scan: all of the above values apply on the next edge. The SPI core shares reset_n and restarts clean.
- Bus access = 3 cycles. One byte ≈ 3+3 accesses plus the SPI shift time of 18×938 cycles.
- Full scan ≈ 6 bytes ≈ 101.4k cycles.
- sample_valid is asserted 1 cycle after the SS_OFF access completes. x_pos/y_pos are stable from that cycle on.
- pen_irq_n to pen_down: 2–3 cycles while in IDLE.

## Test plan
- Reset mid-scan (in RX_WAIT): assert reset_n=0 for 1 cycle -> all outputs at reset values; the next scan starts cleanly after SAMPLE_PERIOD.
- Pen down, bench uses SAMPLE_PERIOD=100 with a real SPI core and a MISO model returning X bytes {00,5A,C8} and Y bytes {00,12,34} -> x_pos=12'hB59, y_pos=12'h246, exactly one sample_valid pulse, SS_n low continuously across all 6 bytes.
- Pen up (pen_irq_n=1) -> no SPI accesses for 5 periods, busy stays 0, pen_down=0.
- Bus checker -> every access is exactly 2 active cycles plus 1 idle; the address sequence per scan is 2, 3, then (1, 0)×6, then 3.
- MISO model with dataavailable forced low, TIMEOUT=50 -> timeout_err=1 after 50 cycles in RX_WAIT, SS_OFF written, x_pos unchanged, no sample_valid; the next good scan clears timeout_err.
- enable→0 during channel Y -> scan completes with sample_valid; no further scans start while enable=0.
